dmem_arbiter: RTL

Two-port arbiter and sequencer in front of the single-port data memory (`DataMem`). It shares the memory between the core load/store port (port 0) and the debug/host loader port (port 1) using round-robin arbitration with an optional lock for atomic read-modify-write sequences. It drives the memory's address, write-data, function and enable inputs, and returns registered responses to each requester.

---
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and DataMem.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // port 0: core load/store
  logic              io_p0_valid;
  logic              io_p0_ready;
  logic [ADDR_W-1:0] io_p0_addr;
  logic [DATA_W-1:0] io_p0_wr_data;
  logic [1:0]        io_p0_func;
  logic              io_p0_lock;
  logic              io_p0_resp_valid;
  logic [DATA_W-1:0] io_p0_resp_data;
  logic              io_p0_resp_err;
  // port 1: debug/host loader
  logic              io_p1_valid;
  logic              io_p1_ready;
  logic [ADDR_W-1:0] io_p1_addr;
  logic [DATA_W-1:0] io_p1_wr_data;
  logic [1:0]        io_p1_func;
  logic              io_p1_lock;
  logic              io_p1_resp_valid;
  logic [DATA_W-1:0] io_p1_resp_data;
  logic              io_p1_resp_err;
  // memory side
  logic [ADDR_W-1:0] io_mem_addr;
  logic [DATA_W-1:0] io_mem_wr_data;
  logic [1:0]        io_mem_func;
  logic              io_mem_en;
  logic [DATA_W-1:0] io_mem_rd_data;

  // arbiter view
  modport slave (
    input  io_p0_valid, io_p0_addr, io_p0_wr_data, io_p0_func, io_p0_lock,
    output io_p0_ready, io_p0_resp_valid, io_p0_resp_data, io_p0_resp_err,
    input  io_p1_valid, io_p1_addr, io_p1_wr_data, io_p1_func, io_p1_lock,
    output io_p1_ready, io_p1_resp_valid, io_p1_resp_data, io_p1_resp_err,
    output io_mem_addr, io_mem_wr_data, io_mem_func, io_mem_en,
    input  io_mem_rd_data
  );

  // requester/memory view
  modport master (
    output io_p0_valid, io_p0_addr, io_p0_wr_data, io_p0_func, io_p0_lock,
    input  io_p0_ready, io_p0_resp_valid, io_p0_resp_data, io_p0_resp_err,
    output io_p1_valid, io_p1_addr, io_p1_wr_data, io_p1_func, io_p1_lock,
    input  io_p1_ready, io_p1_resp_valid, io_p1_resp_data, io_p1_resp_err,
    input  io_mem_addr, io_mem_wr_data, io_mem_func, io_mem_en,
    output io_mem_rd_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with lock, sharing one single-port DataMem.
// Grant is combinational; responses are registered one cycle after grant.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  localparam int NP = 2;

  typedef enum logic [1:0] {OPEN, LOCK0, LOCK1} state_e;

  state_e state_q;
  logic   last_grant_q;

  logic [NP-1:0]             valid, lock, gnt, rvld;
  logic [NP-1:0][ADDR_W-1:0] addr;
  logic [NP-1:0][DATA_W-1:0] wdata, rdata;
  logic [NP-1:0][1:0]        func;
  logic [NP-1:0]             rerr;
  logic                      sel, any;

  assign valid = {bus.io_p1_valid,   bus.io_p0_valid};
  assign lock  = {bus.io_p1_lock,    bus.io_p0_lock};
  assign addr  = {bus.io_p1_addr,    bus.io_p0_addr};
  assign wdata = {bus.io_p1_wr_data, bus.io_p0_wr_data};
  assign func  = {bus.io_p1_func,    bus.io_p0_func};

  // Grant: lock owner only; otherwise round-robin on ties. Nothing during reset.
  always_comb begin
    gnt = '0;
    if (reset) begin
      case (state_q)
        LOCK0:   gnt[0] = valid[0];
        LOCK1:   gnt[1] = valid[1];
        default: begin
          if (valid[0] && (!valid[1] || last_grant_q)) gnt[0] = 1'b1;
          else if (valid[1])                           gnt[1] = 1'b1;
        end
      endcase
    end
  end

  assign sel = gnt[1];
  assign any = |gnt;

  assign bus.io_p0_ready = gnt[0];
  assign bus.io_p1_ready = gnt[1];

  // Memory drive: granted port's fields, zeros when idle; illegal func never enables.
  assign bus.io_mem_addr    = any ? addr[sel]  : '0;
  assign bus.io_mem_wr_data = any ? wdata[sel] : '0;
  assign bus.io_mem_func    = any ? func[sel]  : 2'd0;
  assign bus.io_mem_en      = any && !func[sel][1];

  // Ownership FSM and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= OPEN;
      last_grant_q <= 1'b1;
    end else if (any) begin
      last_grant_q <= sel;
      if (!lock[sel])  state_q <= OPEN;
      else if (sel)    state_q <= LOCK1;
      else             state_q <= LOCK0;
    end
  end

  // Per-port response registers.
  for (genvar p = 0; p < NP; p++) begin : g_resp
    logic              vld_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    // Capture the response at the end of the grant cycle; pulse for one cycle.
    always_ff @(posedge clk) begin
      if (!reset) begin
        vld_q  <= 1'b0;
        data_q <= '0;
        err_q  <= 1'b0;
      end else begin
        vld_q <= gnt[p];
        if (gnt[p]) begin
          data_q <= (func[p] == 2'd0) ? bus.io_mem_rd_data : '0;
          err_q  <= func[p][1];
        end
      end
    end

    assign rvld[p]  = vld_q;
    assign rdata[p] = data_q;
    assign rerr[p]  = err_q;
  end

  assign bus.io_p0_resp_valid = rvld[0];
  assign bus.io_p0_resp_data  = rdata[0];
  assign bus.io_p0_resp_err   = rerr[0];
  assign bus.io_p1_resp_valid = rvld[1];
  assign bus.io_p1_resp_data  = rdata[1];
  assign bus.io_p1_resp_err   = rerr[1];
endmodule
